// File: rtl/logic_pipe_unit.sv
// logic_pipe_unit: op-selected bitwise function of two operands with an optional
// per-frame running XOR checksum, returned over a 1-deep valid/ready output register.
module logic_pipe_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             out_par,
    output logic             out_last,
    output logic [CNT_W-1:0] beat_cnt
);
    // Handshake: a beat moves on any rising edge where valid and ready are both high.
    // The source holds its beat while in_ready=0; the result holds while out_ready=0.
    logic             accept;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] out1_next;
    logic [CNT_W-1:0] fcnt;
    logic [CNT_W-1:0] cnt_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        res = in1;
        case (op)
            3'd0: res = in1 & in2;
            3'd1: res = in1 | in2;
            3'd2: res = in1 ^ in2;
            3'd3: res = ~(in1 & in2);
            3'd4: res = ~(in1 | in2);
            3'd5: res = ~(in1 ^ in2);
            3'd6: res = ~in2;
            3'd7: res = in1;
            default: res = in1;
        endcase
    end

    // Frame beat count sticks at all-ones rather than wrapping.
    assign cnt_next  = (fcnt == {CNT_W{1'b1}}) ? fcnt : fcnt + CNT_W'(1);
    assign acc_next  = acc ^ res;
    assign out1_next = acc_mode ? acc_next : res;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out1      <= '0;
            out2      <= '0;
            out_par   <= 1'b0;
            out_last  <= 1'b0;
            beat_cnt  <= '0;
            acc       <= '0;
            fcnt      <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out1      <= out1_next;
                out2      <= ~in2;
                out_par   <= ^out1_next;
                out_last  <= in_last;
                beat_cnt  <= cnt_next;
                // The last beat reports the pre-clear state, then the frame restarts.
                if (in_last) begin
                    acc  <= '0;
                    fcnt <= '0;
                end else begin
                    fcnt <= cnt_next;
                    if (acc_mode) begin
                        acc <= acc_next;
                    end
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_logic_pipe_unit.sv
// Directed bench for logic_pipe_unit (CNT_W=2 so count saturation is reachable);
// driver pushes expected results, a negedge monitor pops and compares them.
module tb_logic_pipe_unit;
    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in1 = '0;
    logic [WIDTH-1:0] in2 = '0;
    logic [2:0]       op = '0;
    logic             acc_mode = 1'b0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic             out_par;
    logic             out_last;
    logic [CNT_W-1:0] beat_cnt;

    logic_pipe_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .op(op), .acc_mode(acc_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out1(out1), .out2(out2),
        .out_par(out_par), .out_last(out_last), .beat_cnt(beat_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    // {out1, out2, out_par, out_last, beat_cnt}
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out1", 32'(out1), 32'(mon_e[19:12]));
                chk("out2", 32'(out2), 32'(mon_e[11:4]));
                chk("out_par", 32'(out_par), 32'(mon_e[3]));
                chk("out_last", 32'(out_last), 32'(mon_e[2]));
                chk("beat_cnt", 32'(beat_cnt), 32'(mon_e[1:0]));
            end
        end
    end

    // driver
    task automatic send(input logic [2:0] f_op, input logic [7:0] a, input logic [7:0] b,
                        input logic am, input logic lst, input logic [7:0] e1,
                        input logic [1:0] ec);
        int   n;
        logic ok;
        op = f_op; in1 = a; in2 = b; acc_mode = am; in_last = lst; in_valid = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            n++;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        else exp_q.push_back({e1, ~b, ^e1, lst, ec});
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_exp [8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hF0, 8'hA5};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out1", 32'(out1), 32'd0);
        chk("rst_out2", 32'(out2), 32'd0);
        chk("rst_out_par", 32'(out_par), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        idle(1);

        // single XOR beat, valid for exactly one cycle
        send(3'd2, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'hCC, 2'd1);
        @(negedge clk);
        chk("t2_valid_hi", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("t2_valid_lo", 32'(out_valid), 32'd0);
        idle(1);

        // op sweep, back-to-back
        for (int i = 0; i < 8; i++)
            send(i[2:0], 8'hA5, 8'h0F, 1'b0, 1'b1, sweep_exp[i], 2'd1);
        idle(2);

        // checksum frame then the next frame's first beat
        send(3'd7, 8'h01, 8'h00, 1'b1, 1'b0, 8'h01, 2'd1);
        send(3'd7, 8'h02, 8'h00, 1'b1, 1'b0, 8'h03, 2'd2);
        send(3'd7, 8'h04, 8'h00, 1'b1, 1'b1, 8'h07, 2'd3);
        send(3'd7, 8'h10, 8'h00, 1'b1, 1'b1, 8'h10, 2'd1);
        idle(2);

        // back-pressure: one result held while the next beat waits
        out_ready = 1'b0;
        send(3'd2, 8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 2'd1);
        op = 3'd2; in1 = 8'h44; in2 = 8'h88; acc_mode = 1'b0; in_last = 1'b0; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out1", 32'(out1), 32'h33);
            chk("stall_beat_cnt", 32'(beat_cnt), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(3'd2, 8'h44, 8'h88, 1'b0, 1'b0, 8'hCC, 2'd2);
        send(3'd2, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 2'd3);
        send(3'd2, 8'h12, 8'h34, 1'b0, 1'b1, 8'h26, 2'd3);
        idle(3);
        chk("bp_drained_valid", 32'(out_valid), 32'd0);

        // 5-beat checksum frame with saturating count
        send(3'd2, 8'h01, 8'h00, 1'b1, 1'b0, 8'h01, 2'd1);
        send(3'd2, 8'h02, 8'h00, 1'b1, 1'b0, 8'h03, 2'd2);
        send(3'd2, 8'h04, 8'h00, 1'b1, 1'b0, 8'h07, 2'd3);
        send(3'd2, 8'h08, 8'h00, 1'b1, 1'b0, 8'h0F, 2'd3);
        send(3'd2, 8'h10, 8'h00, 1'b1, 1'b1, 8'h1F, 2'd3);
        idle(2);

        // reset mid-frame with a stalled result pending
        send(3'd7, 8'h55, 8'h00, 1'b1, 1'b0, 8'h55, 2'd1);
        idle(2);
        out_ready = 1'b0;
        send(3'd7, 8'h0A, 8'h00, 1'b1, 1'b0, 8'h5F, 2'd2);
        @(negedge clk);
        chk("pend_out1", 32'(out1), 32'h5F);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("midrst_out1", 32'(out1), 32'd0);
        idle(1);
        send(3'd7, 8'h10, 8'h00, 1'b1, 1'b1, 8'h10, 2'd1);
        idle(4);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule
